// File: rtl/oam_dma_if.sv
// Signal bundle between the OAM DMA engine and the CPU-side system:
// $4014 trigger, source memory read port and PPU register write port.
interface oam_dma_if;
  logic        reg_wr;
  logic [7:0]  reg_data;
  logic        cpu_halt;
  logic [15:0] bus_addr;
  logic        bus_rden;
  logic [7:0]  bus_data_in;
  logic [2:0]  ppu_cpu_addr;
  logic [7:0]  ppu_cpu_data_out;
  logic        ppu_cpu_wren;
  logic        dma_done;

  modport master (
    input  reg_wr, reg_data, bus_data_in,
    output cpu_halt, bus_addr, bus_rden, ppu_cpu_addr, ppu_cpu_data_out,
           ppu_cpu_wren, dma_done
  );

  modport slave (
    output reg_wr, reg_data, bus_data_in,
    input  cpu_halt, bus_addr, bus_rden, ppu_cpu_addr, ppu_cpu_data_out,
           ppu_cpu_wren, dma_done
  );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: on a $4014 write, halts the CPU and copies one 256-byte
// CPU page into the PPU OAMDATA port, one read/write cycle pair per byte.
module oam_dma #(
  parameter logic [2:0] OAMDATA_REG = 3'd4,
  parameter int         XFER_LEN    = 256
) (
  input  logic      clk,
  input  logic      reset,
  oam_dma_if.master bus
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state_r;
  logic [7:0]  page_r;
  logic [7:0]  idx_r;
  logic        parity_r;
  logic        cpu_halt_r;
  logic        bus_rden_r;
  logic [15:0] bus_addr_r;
  logic [2:0]  ppu_cpu_addr_r;
  logic        ppu_cpu_wren_r;
  logic        dma_done_r;

  // Transfer sequencer; every output is registered from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      page_r         <= 8'd0;
      idx_r          <= 8'd0;
      parity_r       <= 1'b0;
      cpu_halt_r     <= 1'b0;
      bus_rden_r     <= 1'b0;
      bus_addr_r     <= 16'd0;
      ppu_cpu_addr_r <= 3'd0;
      ppu_cpu_wren_r <= 1'b0;
      dma_done_r     <= 1'b0;
    end else begin
      parity_r       <= ~parity_r;
      cpu_halt_r     <= 1'b0;
      bus_rden_r     <= 1'b0;
      bus_addr_r     <= 16'd0;
      ppu_cpu_addr_r <= 3'd0;
      ppu_cpu_wren_r <= 1'b0;
      dma_done_r     <= 1'b0;
      case (state_r)
        // DONE accepts a new trigger exactly like IDLE, so back-to-back
        // transfers need no idle cycle in between.
        IDLE, DONE: begin
          if (bus.reg_wr) begin
            page_r     <= bus.reg_data;
            idx_r      <= 8'd0;
            cpu_halt_r <= 1'b1;
            state_r    <= HALT;
          end else begin
            state_r <= IDLE;
          end
        end
        HALT: begin
          cpu_halt_r <= 1'b1;
          if (parity_r) begin
            state_r <= ALIGN;
          end else begin
            bus_rden_r <= 1'b1;
            bus_addr_r <= {page_r, idx_r};
            state_r    <= READ;
          end
        end
        ALIGN: begin
          cpu_halt_r <= 1'b1;
          bus_rden_r <= 1'b1;
          bus_addr_r <= {page_r, idx_r};
          state_r    <= READ;
        end
        READ: begin
          cpu_halt_r     <= 1'b1;
          ppu_cpu_wren_r <= 1'b1;
          ppu_cpu_addr_r <= OAMDATA_REG;
          state_r        <= WRITE;
        end
        WRITE: begin
          if (idx_r == LAST_IDX) begin
            dma_done_r <= 1'b1;
            state_r    <= DONE;
          end else begin
            // The page byte is fixed: the index wraps without carrying into it.
            idx_r      <= idx_r + 8'd1;
            cpu_halt_r <= 1'b1;
            bus_rden_r <= 1'b1;
            bus_addr_r <= {page_r, idx_r + 8'd1};
            state_r    <= READ;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_halt         = cpu_halt_r;
  assign bus.bus_rden         = bus_rden_r;
  assign bus.bus_addr         = bus_addr_r;
  assign bus.ppu_cpu_addr     = ppu_cpu_addr_r;
  assign bus.ppu_cpu_wren     = ppu_cpu_wren_r;
  assign bus.dma_done         = dma_done_r;
  // Read data arrives in the WRITE cycle and goes straight through to the PPU.
  assign bus.ppu_cpu_data_out = ppu_cpu_wren_r ? bus.bus_data_in : 8'd0;

endmodule
